lsu_byte_rmw: RTL and testbench
===============================

Name: lsu_byte_rmw

Overview:
Load/store unit between the single-cycle ARM core's data port and a single-ported, synchronous-read data RAM.
- Word loads/stores go through unchanged.
- Byte stores (STRB) use read-modify-write.
- Byte loads (LDRB) are lane-selected and zero-extended.
- Stall freezes the core (PC, register writes) for multi-cycle accesses.

Parameters:
ADDR_W, 6, RAM word-address width (depth = 2**ADDR_W words, default 64)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
MemReq  input  1  core requests a data access this cycle
MemWrite  input  1  1 = store, 0 = load
ByteAccess  input  1  1 = byte access (LDRB/STRB), 0 = word access
Adr  input  32  byte address from ALU
WriteData  input  32  store data; byte store uses WriteData[7:0]
ReadData  output  32  load result to core writeback mux
Stall  output  1  1 = core must hold PC/instruction and not commit this cycle
RamAdr  output  ADDR_W  RAM word index
RamRe  output  1  RAM read enable; data appears on RamRData next cycle
RamWe  output  1  RAM write enable, write on rising edge
RamWData  output  32  RAM write data
RamRData  input  32  RAM read data (registered inside RAM, 1-cycle latency)

Behaviour:
- Reset: state=IDLE, hold register=0, ReadData=0, Stall=0, RamRe=0, RamWe=0, RamAdr=0, RamWData=0.
- Reset mid-operation: abort immediately. No RamWe in the reset cycle or the one after. A partially done RMW leaves RAM unmodified.
- Word index = Adr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Byte lane k = Adr[1:0], little-endian: lane k = bits [8k+7:8k].
- Request capture: at acceptance in IDLE, latch Adr, WriteData[7:0], ByteAccess, MemWrite. The op then completes from the latched copy even if MemReq drops or inputs change.
- Core contract: hold inputs stable while Stall=1.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR.
- IDLE, MemReq=0: outputs idle, Stall=0.
- IDLE, word store: RamWe=1, RamAdr=index, RamWData=WriteData (combinational). Stall=0, stay IDLE. Latency 1 cycle.
- IDLE, load (word or byte): RamRe=1, Stall=1, go to LD_WAIT.
- LD_WAIT: Stall=0, go to IDLE.
  - Word load: ReadData = RamRData.
  - Byte load: ReadData = {24'b0, lane k of RamRData}.
  - The same value loads into the hold register. Total latency 2 cycles.
- IDLE, byte store: RamRe=1, Stall=1, go to RMW_RD.
- RMW_RD: merge register = RamRData with lane k replaced by the latched byte. Stall=1, go to RMW_WR.
- RMW_WR: RamWe=1, RamWData=merge register, Stall=0, go to IDLE. Total latency 3 cycles.
- ReadData outside LD_WAIT = hold register (last load result).
- RamRe and RamWe are never both 1 in a cycle.
- No new request is accepted in any state other than IDLE. A request seen in the cycle Stall falls is the core's next instruction and is accepted on the following cycle in IDLE.
- Back-to-back accesses: no bubble is required beyond the latencies above.

Optional Feature:
Macro LSU_ALIGN_CHECK_EN.
- Defined: adds output port MisAlign (1 bit, reset 0). A word access with Adr[1:0]!=0 is suppressed: no RamWe, no RamRe, ReadData holds, Stall=0. MisAlign sets and stays set until reset.
- Undefined: port is absent; Adr[1:0] is ignored for word accesses.

Test Plan:
- Word store then load: Adr=0x64, WriteData=0x000000FE, store → RamWe same cycle, RAM[25]=0xFE. Load → Stall=1 for 1 cycle, ReadData=0x000000FE.
- Byte store RMW: RAM[4]=0x11223344, STRB WriteData=0xAB, Adr=0x12 → 3 cycles, Stall=1,1,0. RAM[4]=0x11AB3344; RamWe asserted exactly once.
- Byte load all lanes: RAM[4]=0x11AB3344, LDRB Adr=0x10..0x13 → ReadData = 0x44, 0x33, 0xAB, 0x11, zero-extended.
- Reset during RMW_RD of STRB 0xFF to Adr=0x20 → no RamWe occurs. RAM[8] is unchanged, state=IDLE, ReadData=0.
- Input change mid-op: drop MemReq and change Adr to 0x0 during LD_WAIT of a load from 0x64 → the result still reflects RAM[25].
- Wrap and alignment: Adr=0x100 word store hits RAM[0].
  - With LSU_ALIGN_CHECK_EN: word store to Adr=0x62 → no write, MisAlign=1 stays set.

Source files
------------

// File: rtl/lsu_byte_rmw.sv
// Load/store unit between the core data port and a 1-cycle-latency single-port data RAM.
// Byte stores use read-modify-write. Define LSU_ALIGN_CHECK_EN to add the MisAlign port.
module lsu_byte_rmw #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic              ByteAccess,
  input  logic [31:0]       Adr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic [ADDR_W-1:0] RamAdr,
  output logic              RamRe,
  output logic              RamWe,
  output logic [31:0]       RamWData,
  input  logic [31:0]       RamRData
`ifdef LSU_ALIGN_CHECK_EN
  ,
  output logic              MisAlign
`endif
);

  typedef enum logic [1:0] {StIdle, StLdWait, StRmwRd, StRmwWr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [7:0]          byte_q, byte_d;
  logic                bacc_q, bacc_d;
  logic [31:0]         hold_q, hold_d;
  logic [31:0]         merge_q, merge_d;
  logic [7:0]          ld_byte;
  logic [31:0]         rd_val;
  logic                misaligned;

  // Addresses wrap modulo RAM depth, so the upper address bits are intentionally dropped.
  logic unused_adr;
  assign unused_adr = ^Adr[31:ADDR_W+2];

  assign ld_byte = RamRData[{lane_q, 3'b000} +: 8];

`ifdef LSU_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misaligned = !ByteAccess && (Adr[1:0] != 2'b00);
  assign MisAlign   = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    byte_d   = byte_q;
    bacc_d   = bacc_q;
    hold_d   = hold_q;
    merge_d  = merge_q;
    rd_val   = hold_q;
    Stall    = 1'b0;
    RamAdr   = '0;
    RamRe    = 1'b0;
    RamWe    = 1'b0;
    RamWData = '0;
`ifdef LSU_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (MemReq) begin
          if (misaligned) begin
`ifdef LSU_ALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            idx_d  = Adr[ADDR_W+1:2];
            lane_d = Adr[1:0];
            byte_d = WriteData[7:0];
            bacc_d = ByteAccess;
            RamAdr = Adr[ADDR_W+1:2];
            if (MemWrite && !ByteAccess) begin
              RamWe    = 1'b1;
              RamWData = WriteData;
            end else begin
              RamRe   = 1'b1;
              Stall   = 1'b1;
              state_d = MemWrite ? StRmwRd : StLdWait;
            end
          end
        end
      end
      StLdWait: begin
        RamAdr  = idx_q;
        rd_val  = bacc_q ? {24'b0, ld_byte} : RamRData;
        hold_d  = rd_val;
        state_d = StIdle;
      end
      StRmwRd: begin
        RamAdr  = idx_q;
        Stall   = 1'b1;
        merge_d = RamRData;
        merge_d[{lane_q, 3'b000} +: 8] = byte_q;
        state_d = StRmwWr;
      end
      StRmwWr: begin
        RamAdr   = idx_q;
        RamWe    = 1'b1;
        RamWData = merge_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset aborts at once: nothing reaches the RAM or the core in the reset cycle.
    if (reset) begin
      rd_val   = '0;
      Stall    = 1'b0;
      RamAdr   = '0;
      RamRe    = 1'b0;
      RamWe    = 1'b0;
      RamWData = '0;
    end
    ReadData = rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lane_q  <= '0;
      byte_q  <= '0;
      bacc_q  <= 1'b0;
      hold_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      byte_q  <= byte_d;
      bacc_q  <= bacc_d;
      hold_q  <= hold_d;
      merge_q <= merge_d;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_byte_rmw.sv
// Directed, table-driven bench for lsu_byte_rmw with a behavioural 1-cycle-latency RAM.
module tb_lsu_byte_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemWrite, ByteAccess;
  logic [31:0] Adr, WriteData, ReadData;
  logic        Stall;
  logic [5:0]  RamAdr;
  logic        RamRe, RamWe;
  logic [31:0] RamWData;
  logic [31:0] RamRData = '0;
`ifdef LSU_ALIGN_CHECK_EN
  logic        MisAlign;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic mem_clr;
  logic [31:0] mem [64];

  lsu_byte_rmw #(.ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .ByteAccess (ByteAccess),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .RamAdr     (RamAdr),
    .RamRe      (RamRe),
    .RamWe      (RamWe),
    .RamWData   (RamWData),
    .RamRData   (RamRData)
`ifdef LSU_ALIGN_CHECK_EN
    ,
    .MisAlign   (MisAlign)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (RamWe) mem[RamAdr] <= RamWData;
      if (RamRe) RamRData <= mem[RamAdr];
    end
  end

  always @(negedge clk) begin
    if (RamWe) we_cnt++;
    if (RamWe && RamRe) begin
      errors++;
      $display("FAIL re_we_overlap: RamRe=%b RamWe=%b required not both 1", RamRe, RamWe);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that completes the access.
  task automatic do_access(input logic wr, input logic bt, input logic [31:0] adr,
                           input logic [31:0] wd, output int cyc, output int wes,
                           output logic [31:0] rd);
    int   we0;
    logic st;
    we0 = we_cnt;
    MemReq = 1'b1; MemWrite = wr; ByteAccess = bt; Adr = adr; WriteData = wd;
    cyc = 0;
    rd  = '0;
    do begin
      @(negedge clk);
      st = Stall;
      rd = ReadData;
      @(posedge clk);
      #1;
      cyc++;
    end while (st && cyc < 10);
    MemReq = 1'b0; MemWrite = 1'b0; ByteAccess = 1'b0;
    wes = we_cnt - we0;
  endtask

  typedef struct {
    logic        wr;
    logic        bt;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;   // loads: ReadData; stores: resulting RAM word
    int          cyc;
    int          wes;
  } vec_t;

`ifdef LSU_ALIGN_CHECK_EN
  localparam int NV = 15;
`else
  localparam int NV = 17;
`endif

  vec_t        vecs [17];
  int          cyc, wes;
  logic [31:0] rd, last_ld;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0064, 32'h0000_00FE, 32'h0000_00FE, 1, 1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0064, 32'h0,         32'h0000_00FE, 2, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h1122_3344, 1, 1};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_0012, 32'hCDEF_12AB, 32'h11AB_3344, 3, 1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_0044, 2, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0,         32'h0000_0033, 2, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_00AB, 2, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_0011, 2, 0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h11AB_3344, 2, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 2, 0};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0103, 32'h0000_005A, 32'h5AFE_F00D, 3, 1};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,         32'h0000_005A, 2, 0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0020, 32'h8765_4321, 32'h8765_4321, 1, 1};
    vecs[14] = '{1'b0, 1'b0, 32'hFFFF_FF20, 32'h0,         32'h8765_4321, 2, 0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_0062, 32'h1234_5678, 32'h1234_5678, 1, 1};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_0061, 32'h0,         32'h1234_5678, 2, 0};

    reset = 1'b1; mem_clr = 1'b1;
    MemReq = 1'b0; MemWrite = 1'b0; ByteAccess = 1'b0; Adr = '0; WriteData = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_ramre", {31'b0, RamRe}, 32'h0);
    chk("rst_ramwe", {31'b0, RamWe}, 32'h0);
    chk("rst_ramadr", {26'b0, RamAdr}, 32'h0);
    chk("rst_ramwdata", RamWData, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    chk("rst_misalign", {31'b0, MisAlign}, 32'h0);
`endif
    @(posedge clk);
    #1;

    last_ld = '0;
    for (int i = 0; i < NV; i++) begin
      do_access(vecs[i].wr, vecs[i].bt, vecs[i].adr, vecs[i].wd, cyc, wes, rd);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_ramwe_count", i), wes, vecs[i].wes);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_ram_word", i), mem[vecs[i].adr[7:2]], vecs[i].exp);
      end else begin
        chk($sformatf("v%0d_readdata", i), rd, vecs[i].exp);
        last_ld = vecs[i].exp;
      end
    end
    @(negedge clk);
    chk("hold_after_idle", ReadData, last_ld);
    @(posedge clk);
    #1;

    // Reset while a byte store sits in its read phase.
    begin
      int we0;
      MemReq = 1'b1; MemWrite = 1'b1; ByteAccess = 1'b1; Adr = 32'h20; WriteData = 32'hFF;
      @(negedge clk);
      chk("rmw_accept_stall", {31'b0, Stall}, 32'h1);
      @(posedge clk);
      #1;
      MemReq = 1'b0; reset = 1'b1;
      we0 = we_cnt;
      @(negedge clk);
      chk("rst_mid_ramwe", {31'b0, RamWe}, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_stall", {31'b0, Stall}, 32'h0);
      chk("rst_mid_readdata", ReadData, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_no_write", we_cnt - we0, 0);
      chk("rst_mid_ram8", mem[8], 32'h8765_4321);
      do_access(1'b0, 1'b0, 32'h20, 32'h0, cyc, wes, rd);
      chk("post_rst_ld_cycles", cyc, 2);
      chk("post_rst_ld_data", rd, 32'h8765_4321);
    end

    // Inputs change during the load wait; the latched address must still be used.
    MemReq = 1'b1; MemWrite = 1'b0; ByteAccess = 1'b0; Adr = 32'h64;
    @(posedge clk);
    #1 MemReq = 1'b0; Adr = 32'h0;
    @(negedge clk);
    chk("chg_stall", {31'b0, Stall}, 32'h0);
    chk("chg_readdata", ReadData, 32'h0000_00FE);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("chg_hold", ReadData, 32'h0000_00FE);
    @(posedge clk);
    #1;

`ifdef LSU_ALIGN_CHECK_EN
    do_access(1'b1, 1'b0, 32'h62, 32'h1234_5678, cyc, wes, rd);
    chk("mis_st_cycles", cyc, 1);
    chk("mis_st_ramwe_count", wes, 0);
    chk("mis_st_ram24", mem[24], 32'h0);
    chk("mis_flag_set", {31'b0, MisAlign}, 32'h1);
    do_access(1'b0, 1'b0, 32'h61, 32'h0, cyc, wes, rd);
    chk("mis_ld_cycles", cyc, 1);
    chk("mis_ld_hold", rd, 32'h0000_00FE);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, cyc, wes, rd);
    chk("mis_ok_ld_data", rd, 32'h11AB_3344);
    chk("mis_flag_sticky", {31'b0, MisAlign}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
